fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipeline processor.
- Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Owns the IF/ID pipeline register feeding decode. Its r15_d output drives the register file's R15 input (PC+8 of the decode-stage instruction).
- Handles hazard-unit stalls, execute-stage branch redirects, and decode flushes.

---
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fetch_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, the req/ack instruction-memory
// handshake and the IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] r15_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        req_out_q, req_out_d;

    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_r15_q, if_r15_d;
    logic        if_valid_q, if_valid_d;

    logic [31:0] target;
    logic        ack;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic        unused_target_bits;

    // Redirect targets are always word aligned.
    assign target             = {branch_target[31:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    always_comb begin
        state_d       = state_q;
        pc_f_d        = pc_f_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        pend_target_d = pend_target_q;
        req_out_d     = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = pc_f_q;
        ack           = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = pc_f_q;

        case (state_q)
            S_FETCH: begin
                // A request already on the bus stays up until acked.
                imem_req = req_out_q | ~stall_f;
                ack      = imem_req & imem_ack;
                if (ack) begin
                    if (branch_taken) begin
                        pc_f_d = target;
                    end else begin
                        pc_f_d = pc_f_q + 32'd4;
                        if (stall_f) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_f_q;
                            state_d     = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (branch_taken) begin
                    if (imem_req) begin
                        pend_target_d = target;
                        state_d       = S_DROP;
                    end else begin
                        pc_f_d = target;
                    end
                end else begin
                    req_out_d = imem_req;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_f_d  = target;
                    state_d = S_FETCH;
                end else if (!stall_f && !flush_d) begin
                    // A flush only clears IF/ID; the buffered word waits.
                    deliver       = 1'b1;
                    deliver_instr = buf_instr_q;
                    deliver_pc    = buf_pc_q;
                    state_d       = S_FETCH;
                end
            end
            S_DROP: begin
                imem_req = 1'b1;
                ack      = imem_ack;
                if (ack) begin
                    pc_f_d  = branch_taken ? target : pend_target_q;
                    state_d = S_FETCH;
                end else if (branch_taken) begin
                    pend_target_d = target;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            imem_req = 1'b0;
        end
    end

    always_comb begin
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_r15_d   = if_r15_q;
        if_valid_d = if_valid_q;
        if (flush_d || branch_taken) begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else if (stall_f) begin
            if_valid_d = if_valid_q;
        end else if (deliver) begin
            if_instr_d = deliver_instr;
            if_pc_d    = deliver_pc;
            if_r15_d   = deliver_pc + 32'd8;
            if_valid_d = 1'b1;
        end else begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_f_q        <= RESET_PC;
            buf_instr_q   <= 32'd0;
            buf_pc_q      <= 32'd0;
            pend_target_q <= 32'd0;
            req_out_q     <= 1'b0;
            if_instr_q    <= NOP_INSTR;
            if_pc_q       <= 32'd0;
            if_r15_q      <= 32'd0;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_f_q        <= pc_f_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            pend_target_q <= pend_target_d;
            req_out_q     <= req_out_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_r15_q      <= if_r15_d;
            if_valid_q    <= if_valid_d;
        end
    end

    assign instr_d = if_instr_q;
    assign pc_d    = if_pc_q;
    assign r15_d   = if_r15_q;
    assign valid_d = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed handshake scenarios plus a
// randomized run against a transaction-level fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset, stall_f, flush_d, branch_taken, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, valid_d;
    logic [31:0] imem_addr, instr_d, pc_d, r15_d;

    logic        w_reset, w_zero, w_ack, w_req, w_valid;
    logic [31:0] w_zero32, w_rdata, w_addr, w_instr, w_pc, w_r15;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
        .r15_d(r15_d), .valid_d(valid_d)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(w_reset), .stall_f(w_zero), .flush_d(w_zero),
        .branch_taken(w_zero), .branch_target(w_zero32),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
        .imem_rdata(w_rdata), .instr_d(w_instr), .pc_d(w_pc),
        .r15_d(w_r15), .valid_d(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic rs, st, fl, br, input logic [31:0] tg,
                          input logic ak, input logic [31:0] rd);
        @(negedge clk);
        reset = rs; stall_f = st; flush_d = fl; branch_taken = br;
        branch_target = tg; imem_ack = ak; imem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0, 0, 1, 32'h1111_1111);
            checks++;
            if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
            tick();
        end
        checks++;
        if (valid_d !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
        checks++;
        if (instr_d !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_d, NOP); end
        checks++;
        if (pc_d !== 32'd0 || r15_d !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0/0", pc_d, r15_d); end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = i * 4;
            set_in(0, 0, 0, 0, 0, 1, a ^ KEY);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin failures++; $display("FAIL zw_addr got=%b/%h exp=1/%h", imem_req, imem_addr, a); end
            tick();
            checks++;
            if (instr_d !== (a ^ KEY) || pc_d !== a || r15_d !== a + 32'd8 || valid_d !== 1'b1) begin
                failures++;
                $display("FAIL zw_ifid got=%h/%h/%h/%b exp=%h/%h/%h/1", instr_d, pc_d, r15_d, valid_d, a ^ KEY, a, a + 32'd8);
            end
        end
        $display("test_zero_wait done");
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 32'h0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL ws_addr got=%b/%h exp=1/10", imem_req, imem_addr); end
            tick();
            checks++;
            if (valid_d !== 1'b0 || instr_d !== NOP) begin failures++; $display("FAIL ws_bubble got=%b/%h exp=0/%h", valid_d, instr_d, NOP); end
        end
        set_in(0, 0, 0, 0, 0, 1, 32'h10 ^ KEY);
        checks++;
        if (imem_addr !== 32'h10) begin failures++; $display("FAIL ws_ack_addr got=%h exp=10", imem_addr); end
        tick();
        checks++;
        if (instr_d !== (32'h10 ^ KEY) || pc_d !== 32'h10 || r15_d !== 32'h18 || valid_d !== 1'b1) begin
            failures++;
            $display("FAIL ws_load got=%h/%h/%h/%b exp=%h/10/18/1", instr_d, pc_d, r15_d, valid_d, 32'h10 ^ KEY);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h14 + i * 4;
            set_in(0, 0, 0, 0, 0, 1, a ^ KEY);
            checks++;
            if (imem_addr !== a) begin failures++; $display("FAIL ws_seq got=%h exp=%h", imem_addr, a); end
            tick();
        end
        $display("test_wait_states done");
    endtask

    task automatic test_stall_capture();
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin failures++; $display("FAIL sc_addr got=%b/%h exp=1/20", imem_req, imem_addr); end
        tick();
        set_in(0, 1, 0, 0, 0, 1, 32'h20 ^ KEY);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin failures++; $display("FAIL sc_held_req got=%b/%h exp=1/20", imem_req, imem_addr); end
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
            checks++;
            if (imem_req !== 1'b0) begin failures++; $display("FAIL sc_hold_req got=%b exp=0", imem_req); end
            tick();
            checks++;
            if (valid_d !== 1'b0 || instr_d !== NOP) begin failures++; $display("FAIL sc_hold_ifid got=%b/%h exp=0/%h", valid_d, instr_d, NOP); end
        end
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL sc_release_req got=%b exp=0", imem_req); end
        tick();
        checks++;
        if (pc_d !== 32'h20 || instr_d !== (32'h20 ^ KEY) || valid_d !== 1'b1) begin
            failures++;
            $display("FAIL sc_release_ifid got=%h/%h/%b exp=20/%h/1", pc_d, instr_d, valid_d, 32'h20 ^ KEY);
        end
        set_in(0, 0, 0, 0, 0, 1, 32'h24 ^ KEY);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin failures++; $display("FAIL sc_next got=%b/%h exp=1/24", imem_req, imem_addr); end
        tick();
        $display("test_stall_capture done");
    endtask

    task automatic test_redirect_wait();
        logic       brs [5];
        logic [31:0] tgs [5];
        logic       aks [5];
        brs = '{0, 1, 0, 1, 0};
        tgs = '{32'h0, 32'h100, 32'h0, 32'h200, 32'h0};
        aks = '{0, 0, 0, 0, 1};
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 1, (32'h28 + i * 4) ^ KEY);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, brs[i], tgs[i], aks[i], 32'h30 ^ KEY);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin failures++; $display("FAIL rw_addr[%0d] got=%b/%h exp=1/30", i, imem_req, imem_addr); end
            tick();
            checks++;
            if (valid_d !== 1'b0) begin failures++; $display("FAIL rw_valid[%0d] got=%b exp=0", i, valid_d); end
        end
        set_in(0, 0, 0, 0, 0, 1, 32'h200 ^ KEY);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rw_target got=%b/%h exp=1/200", imem_req, imem_addr); end
        tick();
        checks++;
        if (pc_d !== 32'h200 || valid_d !== 1'b1) begin failures++; $display("FAIL rw_load got=%h/%b exp=200/1", pc_d, valid_d); end
        $display("test_redirect_wait done");
    endtask

    task automatic test_redirect_ack_stall();
        set_in(0, 0, 0, 1, 32'h40, 1, 32'h0);
        checks++;
        if (imem_addr !== 32'h204) begin failures++; $display("FAIL ras_pre got=%h exp=204", imem_addr); end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL ras_addr got=%b/%h exp=1/40", imem_req, imem_addr); end
        tick();
        set_in(0, 1, 0, 1, 32'h83, 1, 32'h40 ^ KEY);
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL ras_req got=%b exp=1", imem_req); end
        tick();
        checks++;
        if (valid_d !== 1'b0 || instr_d !== NOP) begin failures++; $display("FAIL ras_valid got=%b/%h exp=0/%h", valid_d, instr_d, NOP); end
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL ras_target got=%b/%h exp=1/80", imem_req, imem_addr); end
        tick();
        $display("test_redirect_ack_stall done");
    endtask

    task automatic test_reset_mid();
        set_in(1, 0, 0, 0, 0, 0, 32'h0);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_req got=%b exp=0", imem_req); end
        tick();
        checks++;
        if (valid_d !== 1'b0 || instr_d !== NOP) begin failures++; $display("FAIL rm_ifid got=%b/%h exp=0/%h", valid_d, instr_d, NOP); end
        set_in(1, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_late_req got=%b exp=0", imem_req); end
        tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h0 ^ KEY);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rm_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
        tick();
        checks++;
        if (pc_d !== 32'h0 || instr_d !== KEY || valid_d !== 1'b1) begin failures++; $display("FAIL rm_load got=%h/%h/%b exp=0/%h/1", pc_d, instr_d, valid_d, KEY); end
        $display("test_reset_mid done");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        w_reset = 1'b1; w_ack = 1'b0;
        tick();
        @(negedge clk);
        w_reset = 1'b0; w_ack = 1'b1; w_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", w_req, w_addr); end
        tick();
        checks++;
        if (w_pc !== 32'hFFFF_FFFC || w_r15 !== 32'h4 || w_instr !== 32'h1234_5678 || w_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_ifid got=%h/%h/%h/%b exp=fffffffc/4/12345678/1", w_pc, w_r15, w_instr, w_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (w_addr !== 32'h0) begin failures++; $display("FAIL wrap_second got=%h exp=0", w_addr); end
        $display("test_wrap done");
    endtask

    // Reference model: the fetch unit seen as "next address", an optional
    // request on the bus, an optional captured word, an optional redirect.
    task automatic test_random();
        logic [31:0] m_pc, m_redir, m_bi, m_bp, m_instr, m_pcd, m_r15;
        logic        m_out, m_hold, m_drop, m_valid;
        set_in(1, 0, 0, 0, 0, 0, 32'h0);
        tick();
        m_pc = 32'h0; m_redir = 0; m_bi = 0; m_bp = 0;
        m_out = 0; m_hold = 0; m_drop = 0;
        m_instr = NOP; m_pcd = 0; m_r15 = 0; m_valid = 0;
        for (int n = 0; n < 1500; n++) begin
            logic st, fl, br, ak, ereq, acc, dlv;
            logic [31:0] tg, rd, tga, d_i, d_p;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            br = ($urandom_range(0, 9) == 0);
            ak = $urandom_range(0, 1) == 1;
            tg = $urandom;
            rd = $urandom;
            tga = {tg[31:2], 2'b00};
            set_in(0, st, fl, br, tg, ak, rd);
            ereq = m_drop ? 1'b1 : (m_hold ? 1'b0 : (m_out | ~st));
            checks++;
            if (imem_req !== ereq) begin failures++; $display("FAIL rnd_req[%0d] got=%b exp=%b", n, imem_req, ereq); end
            if (ereq) begin
                checks++;
                if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", n, imem_addr, m_pc); end
            end
            acc = ereq & ak;
            dlv = 0; d_i = 0; d_p = 0;
            if (m_hold) begin
                if (br) begin m_hold = 0; m_pc = tga; end
                else if (!st && !fl) begin dlv = 1; d_i = m_bi; d_p = m_bp; m_hold = 0; end
            end else if (m_drop) begin
                if (acc) begin m_pc = br ? tga : m_redir; m_drop = 0; end
                else if (br) m_redir = tga;
            end else begin
                m_out = 0;
                if (acc) begin
                    if (br) m_pc = tga;
                    else if (!st) begin dlv = 1; d_i = rd; d_p = m_pc; m_pc = m_pc + 4; end
                    else begin m_bi = rd; m_bp = m_pc; m_hold = 1; m_pc = m_pc + 4; end
                end else if (br) begin
                    if (ereq) begin m_drop = 1; m_redir = tga; end
                    else m_pc = tga;
                end else begin
                    m_out = ereq;
                end
            end
            if (fl || br) begin m_instr = NOP; m_valid = 0; end
            else if (!st) begin
                if (dlv) begin m_instr = d_i; m_pcd = d_p; m_r15 = d_p + 8; m_valid = 1; end
                else begin m_instr = NOP; m_valid = 0; end
            end
            tick();
            checks++;
            if (valid_d !== m_valid || instr_d !== m_instr) begin
                failures++;
                $display("FAIL rnd_ifid[%0d] got=%b/%h exp=%b/%h", n, valid_d, instr_d, m_valid, m_instr);
            end
            if (m_valid) begin
                checks++;
                if (pc_d !== m_pcd || r15_d !== m_r15) begin
                    failures++;
                    $display("FAIL rnd_pc[%0d] got=%h/%h exp=%h/%h", n, pc_d, r15_d, m_pcd, m_r15);
                end
                if (dlv && !st) $display("txn %0d pc=%h instr=%h", n, m_pcd, m_instr);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        reset = 1'b1; stall_f = 0; flush_d = 0; branch_taken = 0;
        branch_target = 0; imem_ack = 0; imem_rdata = 0;
        w_reset = 1'b1; w_zero = 1'b0; w_zero32 = 32'd0; w_ack = 0; w_rdata = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_capture();
        test_redirect_wait();
        test_redirect_ack_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
